// File: rtl/mips_mc_pkg.sv
// Shared constants and types for the multicycle MIPS control path.
package mips_mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    // Registered sequencer state encoding, also exported on state_o.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    // Primary opcodes, instruction[31:26].
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    // ALU operation codes understood by the ALU control block.
    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b101;

    // Datapath control word produced per state.
    typedef struct packed {
        logic               pc_write;
        logic               pc_write_cond;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               reg_write;
        logic               alu_src_a;
        logic               signe;
        logic [SEL_W-1:0]   reg_dst;
        logic [SEL_W-1:0]   mem_to_reg;
        logic [SEL_W-1:0]   alu_src_b;
        logic [SEL_W-1:0]   pc_source;
        logic [ALUOP_W-1:0] alu_op;
        logic               instr_done;
        logic               illegal;
    } ctrl_t;

    // ALU operation for the immediate-arithmetic group; add for anything else.
    function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: imm_alu_op = ALU_AND;
            OP_ORI:  imm_alu_op = ALU_OR;
            default: imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control-word decode from the current state and opcode.
module mips_mc_outdec
    import mips_mc_pkg::*;
(
    input  state_e                i_state,
    input  logic [OPCODE_W-1:0]   i_opcode,
    input  logic                  i_mem_ready,
    output ctrl_t                 o_ctrl
);

    // Per-state control word; everything not named for a state stays 0.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = 2'b01;
                if (i_mem_ready) begin
                    o_ctrl.ir_write  = 1'b1;
                    o_ctrl.pc_write  = 1'b1;
                    o_ctrl.pc_source = 2'b00;
                end
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = 2'b11;
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.signe     = 1'b1;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 2'b00;
                o_ctrl.mem_to_reg = 2'b01;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.iord       = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_REXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b00;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 2'b01;
                o_ctrl.mem_to_reg = 2'b00;
                o_ctrl.instr_done = 1'b1;
            end
            S_IEXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 2'b10;
                o_ctrl.alu_op    = imm_alu_op(i_opcode);
                o_ctrl.signe     = (i_opcode == OP_ADDI);
            end
            S_IWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = 2'b00;
                o_ctrl.mem_to_reg = 2'b00;
                o_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = 2'b00;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = 2'b01;
                o_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = 2'b10;
                o_ctrl.instr_done = 1'b1;
                if (i_opcode == OP_JAL) begin
                    o_ctrl.reg_write  = 1'b1;
                    o_ctrl.reg_dst    = 2'b10;
                    o_ctrl.mem_to_reg = 2'b10;
                end
            end
            S_TRAP: begin
                o_ctrl.illegal = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multicycle MIPS main control: state register, next-state logic, gated outputs.
module mips_mc_sequencer
    import mips_mc_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic                  signe,
    output logic [SEL_W-1:0]      reg_dst,
    output logic [SEL_W-1:0]      mem_to_reg,
    output logic [SEL_W-1:0]      alu_src_b,
    output logic [SEL_W-1:0]      pc_source,
    output logic [ALUOP_W-1:0]    alu_op,
    output logic                  instr_done,
    output logic                  illegal,
    output logic [STATE_W-1:0]    state_o
);

    state_e r_state;
    state_e w_next;
    ctrl_t  w_ctrl;

    // State register; a low reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; memory states wait on mem_ready.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              w_next = S_MEMADR;
                    OP_RTYPE:                  w_next = S_REXEC;
                    OP_ADDI, OP_ANDI, OP_ORI:  w_next = S_IEXEC;
                    OP_BEQ:                    w_next = S_BRANCH;
                    OP_J, OP_JAL:              w_next = S_JUMP;
                    default:                   w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_REXEC:  w_next = S_RWB;
            S_IEXEC:  w_next = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
                w_next = S_FETCH;
            end
            S_TRAP: begin
                w_next = HALT_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    mips_mc_outdec u_outdec (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Strobes are forced low while reset is held; selects pass straight through.
    assign pc_write      = w_ctrl.pc_write      & reset;
    assign pc_write_cond = w_ctrl.pc_write_cond & reset;
    assign mem_read      = w_ctrl.mem_read      & reset;
    assign mem_write     = w_ctrl.mem_write     & reset;
    assign ir_write      = w_ctrl.ir_write      & reset;
    assign reg_write     = w_ctrl.reg_write     & reset;
    assign instr_done    = w_ctrl.instr_done    & reset;
    assign illegal       = w_ctrl.illegal       & reset;
    assign iord          = w_ctrl.iord;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign signe         = w_ctrl.signe;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign pc_source     = w_ctrl.pc_source;
    assign alu_op        = w_ctrl.alu_op;
    assign state_o       = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Bench for mips_mc_sequencer: directed scenarios plus a scoreboarded random stream.
module tb_mips_mc_sequencer;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset, r1, mem_ready;
    logic [5:0] opcode;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, signe;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal;
    logic [3:0] state_o;

    logic       d1_pc_write, d1_pc_write_cond, d1_iord, d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_write, d1_alu_src_a, d1_signe;
    logic [1:0] d1_reg_dst, d1_mem_to_reg, d1_alu_src_b, d1_pc_source;
    logic [2:0] d1_alu_op;
    logic       d1_instr_done, d1_illegal;
    logic [3:0] d1_state_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // Expected outcome of one instruction, seen at its retire/trap cycle.
    typedef struct {
        int cycles;
        int trap;
        int rw, rdst, m2r, pw, pwc, psrc, mw, mr;
        int pre_alu, pre_signe, ret_alu;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mips_mc_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .signe(signe), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
        .pc_source(pc_source), .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
        .state_o(state_o)
    );

    mips_mc_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
        .clk(clk), .reset(r1), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(d1_pc_write), .pc_write_cond(d1_pc_write_cond), .iord(d1_iord), .mem_read(d1_mem_read),
        .mem_write(d1_mem_write), .ir_write(d1_ir_write), .reg_write(d1_reg_write), .alu_src_a(d1_alu_src_a),
        .signe(d1_signe), .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg), .alu_src_b(d1_alu_src_b),
        .pc_source(d1_pc_source), .alu_op(d1_alu_op), .instr_done(d1_instr_done), .illegal(d1_illegal),
        .state_o(d1_state_o)
    );

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic dcyc(input logic mr, input state_e st, input string nm);
        mem_ready = mr;
        @(negedge clk);
        chk(nm, int'(state_o), int'(st));
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Architectural expectation per opcode, independent of how the control is built.
    function automatic exp_t model(input logic [5:0] op);
        exp_t e;
        e = '{cycles:0, trap:0, rw:0, rdst:0, m2r:0, pw:0, pwc:0, psrc:0, mw:0, mr:0,
              pre_alu:-1, pre_signe:-1, ret_alu:-1};
        case (op)
            OP_LW:    begin e.rw = 1; e.m2r = 1; end
            OP_SW:    begin e.mw = 1; end
            OP_RTYPE: begin e.rw = 1; e.rdst = 1; e.pre_alu = 2; e.pre_signe = 0; end
            OP_ADDI:  begin e.rw = 1; e.pre_alu = 0; e.pre_signe = 1; end
            OP_ANDI:  begin e.rw = 1; e.pre_alu = 4; e.pre_signe = 0; end
            OP_ORI:   begin e.rw = 1; e.pre_alu = 5; e.pre_signe = 0; end
            OP_BEQ:   begin e.pwc = 1; e.psrc = 1; e.ret_alu = 1; end
            OP_J:     begin e.pw = 1; e.psrc = 2; end
            OP_JAL:   begin e.pw = 1; e.psrc = 2; e.rw = 1; e.rdst = 2; e.m2r = 2; end
            default:  begin e.trap = 1; end
        endcase
        return e;
    endfunction

    // Plan one instruction's mem_ready timeline from access counts, push its expectation, drive it.
    task automatic run_instr(input logic [5:0] op);
        exp_t e;
        bit   plan[$];
        int   f, d, base_rest;
        f = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        e = model(op);
        repeat (f) plan.push_back(1'b0);
        plan.push_back(1'b1);
        if (op == OP_LW || op == OP_SW) begin
            plan.push_back(1'($urandom_range(0, 1)));
            plan.push_back(1'($urandom_range(0, 1)));
            repeat (d) plan.push_back(1'b0);
            plan.push_back(1'b1);
            if (op == OP_LW) plan.push_back(1'($urandom_range(0, 1)));
        end else begin
            base_rest = (op == OP_RTYPE || op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? 3 : 2;
            repeat (base_rest) plan.push_back(1'($urandom_range(0, 1)));
        end
        e.cycles = plan.size();
        sb.push_back(e);
        for (int i = 0; i < plan.size(); i++) begin
            opcode    = (i <= f) ? 6'($urandom) : op;
            mem_ready = plan[i];
            adv();
        end
    endtask

    // Monitor: count cycles per instruction and score each retire or trap.
    initial begin : monitor
        int cyc;
        int prev_alu, prev_signe;
        exp_t e;
        cyc = 0; prev_alu = 0; prev_signe = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!reset) begin
                    cyc = 0;
                end else begin
                    cyc++;
                    if (mem_write && pc_write) chk("mw_pw_exclusive", 1, 0);
                    if (mem_read && mem_write) chk("mr_mw_exclusive", 1, 0);
                    if (instr_done || illegal) begin
                        chk("sb_has_entry", int'(sb.size() != 0), 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("latency", cyc, e.cycles);
                            chk("illegal", int'(illegal), e.trap);
                            chk("instr_done", int'(instr_done), 1 - e.trap);
                            chk("reg_write", int'(reg_write), e.rw);
                            chk("mem_write", int'(mem_write), e.mw);
                            chk("mem_read", int'(mem_read), e.mr);
                            chk("pc_write", int'(pc_write), e.pw);
                            chk("pc_write_cond", int'(pc_write_cond), e.pwc);
                            if (e.rw != 0) begin
                                chk("reg_dst", int'(reg_dst), e.rdst);
                                chk("mem_to_reg", int'(mem_to_reg), e.m2r);
                            end
                            if (e.pw != 0 || e.pwc != 0) chk("pc_source", int'(pc_source), e.psrc);
                            if (e.pre_alu >= 0) chk("exec_alu_op", prev_alu, e.pre_alu);
                            if (e.pre_signe >= 0) chk("exec_signe", prev_signe, e.pre_signe);
                            if (e.ret_alu >= 0) chk("branch_alu_op", int'(alu_op), e.ret_alu);
                        end
                        cyc = 0;
                    end
                    prev_alu   = int'(alu_op);
                    prev_signe = int'(signe);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then a random instruction stream.
    initial begin : stim
        state_e st_r[4];
        logic [5:0] op;
        reset = 1'b0; r1 = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
        st_r[0] = S_FETCH; st_r[1] = S_DECODE; st_r[2] = S_REXEC; st_r[3] = S_RWB;

        // Strobes held low during reset even though FETCH would request memory.
        repeat (2) adv();
        @(negedge clk);
        chk("rst_state", int'(state_o), int'(S_FETCH));
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_ir_write", int'(ir_write), 0);
        chk("rst_pc_write", int'(pc_write), 0);
        adv();
        reset = 1'b1;

        // R-type with memory always ready.
        for (int i = 0; i < 4; i++) begin
            dcyc(1'b1, st_r[i], "rtype_state");
            if (i == 0) begin
                chk("fetch_ir_write", int'(ir_write), 1);
                chk("fetch_pc_write", int'(pc_write), 1);
            end
            if (i == 3) begin
                chk("rwb_reg_write", int'(reg_write), 1);
                chk("rwb_reg_dst", int'(reg_dst), 1);
            end
            chk("rtype_done", int'(instr_done), (i == 3) ? 1 : 0);
            adv();
        end

        // lw with three stalled cycles in MEMRD.
        opcode = OP_LW;
        dcyc(1'b1, S_FETCH, "lw_state"); adv();
        dcyc(1'b1, S_DECODE, "lw_state"); adv();
        dcyc(1'b1, S_MEMADR, "lw_state"); adv();
        for (int k = 0; k < 4; k++) begin
            dcyc((k == 3), S_MEMRD, "lw_memrd_state");
            chk("lw_mem_read", int'(mem_read), 1);
            chk("lw_iord", int'(iord), 1);
            chk("lw_no_done", int'(instr_done), 0);
            adv();
        end
        dcyc(1'b1, S_MEMWB, "lw_state");
        chk("lw_done", int'(instr_done), 1);
        chk("lw_mem_to_reg", int'(mem_to_reg), 1);
        adv();

        // jal then j.
        opcode = OP_JAL;
        dcyc(1'b1, S_FETCH, "jal_state"); adv();
        dcyc(1'b1, S_DECODE, "jal_state"); adv();
        dcyc(1'b1, S_JUMP, "jal_state");
        chk("jal_pc_write", int'(pc_write), 1);
        chk("jal_pc_source", int'(pc_source), 2);
        chk("jal_reg_write", int'(reg_write), 1);
        chk("jal_reg_dst", int'(reg_dst), 2);
        chk("jal_mem_to_reg", int'(mem_to_reg), 2);
        adv();
        opcode = OP_J;
        dcyc(1'b1, S_FETCH, "j_state"); adv();
        dcyc(1'b1, S_DECODE, "j_state"); adv();
        dcyc(1'b1, S_JUMP, "j_state");
        chk("j_reg_write", int'(reg_write), 0);
        chk("j_pc_write", int'(pc_write), 1);
        adv();

        // Illegal opcode on both builds: one-cycle trap vs. held trap.
        opcode = 6'b111111;
        r1 = 1'b1;
        dcyc(1'b1, S_FETCH, "ill_state"); adv();
        dcyc(1'b1, S_DECODE, "ill_state"); adv();
        dcyc(1'b1, S_TRAP, "ill_state");
        chk("ill_flag", int'(illegal), 1);
        chk("ill_no_done", int'(instr_done), 0);
        chk("ill_no_pc_write", int'(pc_write), 0);
        chk("ill_no_reg_write", int'(reg_write), 0);
        chk("halt_ill_flag", int'(d1_illegal), 1);
        adv();
        dcyc(1'b0, S_FETCH, "ill_exit_state");
        chk("ill_cleared", int'(illegal), 0);
        adv();
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("halt_state", int'(d1_state_o), int'(S_TRAP));
            chk("halt_ill_held", int'(d1_illegal), 1);
            chk("halt_no_done", int'(d1_instr_done), 0);
            adv();
        end
        r1 = 1'b0;
        @(negedge clk);
        chk("halt_ill_rst", int'(d1_illegal), 0);
        adv();
        @(negedge clk);
        chk("halt_rst_state", int'(d1_state_o), int'(S_FETCH));
        adv();

        // Reset during a stalled store.
        opcode = OP_SW;
        dcyc(1'b1, S_FETCH, "sw_state"); adv();
        dcyc(1'b1, S_DECODE, "sw_state"); adv();
        dcyc(1'b1, S_MEMADR, "sw_state");
        chk("memadr_signe", int'(signe), 1);
        adv();
        dcyc(1'b0, S_MEMWR, "sw_state");
        chk("sw_mem_write", int'(mem_write), 1);
        chk("sw_iord", int'(iord), 1);
        chk("sw_stall_no_done", int'(instr_done), 0);
        adv();
        mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("sw_rst_mem_write", int'(mem_write), 0);
        chk("sw_rst_no_done", int'(instr_done), 0);
        adv();
        reset = 1'b1;
        dcyc(1'b0, S_FETCH, "sw_after_rst_state");
        chk("refetch_mem_read", int'(mem_read), 1);
        chk("refetch_ir_write", int'(ir_write), 0);
        adv();

        // Random instruction stream against the scoreboard.
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) adv();
        reset = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                case ($urandom_range(0, 8))
                    0: op = OP_RTYPE;
                    1: op = OP_J;
                    2: op = OP_JAL;
                    3: op = OP_BEQ;
                    4: op = OP_ADDI;
                    5: op = OP_ANDI;
                    6: op = OP_ORI;
                    7: op = OP_LW;
                    default: op = OP_SW;
                endcase
            end
            run_instr(op);
        end
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
